// File: rtl/uart_programmer.sv
// UART loader: 8N1 receiver feeding a header/data session FSM that writes 32-bit words to ROM or RAM.
// Latency: a write strobe follows the 4th byte's stop-bit sample by 2 cycles; done follows the last strobe by 1 cycle.
// Backpressure: none; the serial line cannot be stalled, and the memory must accept a strobe on every word.
module uart_programmer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        rx,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        err_o
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} ses_state_t;

    rx_state_t  rx_state, rx_state_nxt;
    ses_state_t ses_state, ses_state_nxt;

    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] bit_tmr;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_byte;
    logic        byte_valid, frame_err;
    logic        tmr_hit;

    logic        target;
    logic [1:0]  byte_cnt;
    logic [13:0] word_cnt;
    logic [13:0] word_idx;
    logic [23:0] word_buf;

    // Start bit is checked at its middle; every later sample is a full bit period apart.
    assign tmr_hit = (rx_state == RX_START) ? (bit_tmr == HALF_BIT) : (bit_tmr == FULL_BIT);

    // Receiver next-state: falling edge starts a frame, a high mid-start-bit is treated as a glitch.
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            RX_START: if (tmr_hit) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tmr_hit && bit_idx == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (tmr_hit) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    // Receiver datapath: synchronizer, bit timer, LSB-first shift register, byte/framing pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_tmr    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_nxt;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            bit_tmr    <= (rx_state == RX_IDLE || tmr_hit) ? 16'd0 : bit_tmr + 16'd1;
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && tmr_hit) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_state == RX_STOP && tmr_hit) begin
                byte_valid <= rx_sync;
                frame_err  <= ~rx_sync;
            end
        end
    end

    // Session next-state: framing errors win over everything; bytes only matter in HDR/DATA.
    always_comb begin
        ses_state_nxt = ses_state;
        if (frame_err) begin
            ses_state_nxt = ERR;
        end else begin
            case (ses_state)
                IDLE, DONE, ERR: if (start_pg) ses_state_nxt = HDR;
                HDR: begin
                    if (byte_valid) begin
                        if (byte_cnt == 2'd0 && rx_byte[7:1] != 7'd0)
                            ses_state_nxt = ERR;
                        else if (byte_cnt == 2'd2)
                            ses_state_nxt = ({rx_byte[5:0], word_cnt[7:0]} == 14'd0) ? DONE : DATA;
                    end
                end
                DATA:    if (upg_wen_o && word_idx == word_cnt) ses_state_nxt = DONE;
                default: ses_state_nxt = IDLE;
            endcase
        end
    end

    // Session datapath: header capture, word assembly, write strobe and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ses_state  <= IDLE;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
            target     <= 1'b0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_idx   <= '0;
            word_buf   <= '0;
        end else begin
            ses_state <= ses_state_nxt;
            upg_wen_o <= 1'b0;
            if (ses_state_nxt == HDR && ses_state != HDR) begin
                upg_done_o <= 1'b0;
                err_o      <= 1'b0;
                byte_cnt   <= '0;
                word_idx   <= '0;
            end
            if (ses_state == HDR && byte_valid) begin
                case (byte_cnt)
                    2'd0:    target <= rx_byte[0];
                    2'd1:    word_cnt[7:0] <= rx_byte;
                    default: word_cnt[13:8] <= rx_byte[5:0];
                endcase
                byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
            end
            if (ses_state == DATA && byte_valid) begin
                case (byte_cnt)
                    2'd0: word_buf[7:0]   <= rx_byte;
                    2'd1: word_buf[15:8]  <= rx_byte;
                    2'd2: word_buf[23:16] <= rx_byte;
                    default: begin
                        upg_dat_o <= {rx_byte, word_buf};
                        upg_adr_o <= {target, word_idx};
                        upg_wen_o <= 1'b1;
                        word_idx  <= word_idx + 14'd1;
                    end
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end
            if ((ses_state == HDR || ses_state == DATA) && ses_state_nxt == DONE)
                upg_done_o <= 1'b1;
            if ((ses_state == HDR && ses_state_nxt == ERR) || frame_err)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_programmer.sv
// Directed bench for uart_programmer: serial byte stimulus, strobe logger, hand-computed expectations.
// Latency: checks done rises exactly one cycle after the final write strobe.
// Backpressure: not applicable; stimulus is free-running serial frames.
module tb_uart_programmer;

    localparam int CPB = 87;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_pg = 1'b0;
    logic        rx = 1'b1;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        err_o;

    int n_vec = 0;
    int n_miss = 0;

    int          cyc = 0;
    int          n_strb = 0;
    int          strb_cyc = 0;
    int          done_cyc = 0;
    int          dbl_wen = 0;
    logic        wen_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [14:0] log_adr [16];
    logic [31:0] log_dat [16];
    int          base;

    uart_programmer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_pg   (start_pg),
        .rx         (rx),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe and the rising edge of done, sampled away from the active edge.
    always @(negedge clk) begin
        if (upg_wen_o) begin
            if (n_strb < 16) begin
                log_adr[n_strb] = upg_adr_o;
                log_dat[n_strb] = upg_dat_o;
            end
            n_strb   = n_strb + 1;
            strb_cyc = cyc;
            if (wen_prev) dbl_wen = dbl_wen + 1;
        end
        if (upg_done_o && !done_prev) done_cyc = cyc;
        wen_prev  = upg_wen_o;
        done_prev = upg_done_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bs [], input int n);
        for (int i = 0; i < n; i++) send_byte(bs[i], 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_pg = 1'b1;
        @(negedge clk);
        start_pg = 1'b0;
    endtask

    logic [7:0] s1 [] = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] s2 [] = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] s3 [] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] s4 [] = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    logic [7:0] s5 [] = '{8'h05, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] s6 [] = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    logic [7:0] s7 [] = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] s8 [] = '{8'h00, 8'h01, 8'h00};
    logic [7:0] s9 [] = '{8'hBB, 8'hCC, 8'hDD};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wen",  {31'd0, upg_wen_o}, 32'd0);
        chk("rst_adr",  {17'd0, upg_adr_o}, 32'd0);
        chk("rst_dat",  upg_dat_o, 32'd0);
        chk("rst_done", {31'd0, upg_done_o}, 32'd0);
        chk("rst_err",  {31'd0, err_o}, 32'd0);

        // Two ROM words.
        base = n_strb;
        pulse_start();
        send_bytes(s1, 11);
        repeat (10) @(negedge clk);
        chk("s1_nstrb", n_strb - base, 2);
        chk("s1_adr0", {17'd0, log_adr[base]}, 32'h0000);
        chk("s1_dat0", log_dat[base], 32'h12345678);
        chk("s1_adr1", {17'd0, log_adr[base+1]}, 32'h0001);
        chk("s1_dat1", log_dat[base+1], 32'hDEADBEEF);
        chk("s1_done", {31'd0, upg_done_o}, 32'd1);
        chk("s1_done_lat", done_cyc - strb_cyc, 1);
        chk("s1_dat_hold", upg_dat_o, 32'hDEADBEEF);

        // One RAM word.
        base = n_strb;
        pulse_start();
        chk("s2_done_clr", {31'd0, upg_done_o}, 32'd0);
        send_bytes(s2, 7);
        repeat (10) @(negedge clk);
        chk("s2_nstrb", n_strb - base, 1);
        chk("s2_adr", {17'd0, log_adr[base]}, 32'h4000);
        chk("s2_dat", log_dat[base], 32'h44332211);
        chk("s2_done", {31'd0, upg_done_o}, 32'd1);
        chk("s2_done_lat", done_cyc - strb_cyc, 1);

        // Zero-length session.
        base = n_strb;
        pulse_start();
        send_bytes(s3, 3);
        repeat (10) @(negedge clk);
        chk("s3_nstrb", n_strb - base, 0);
        chk("s3_done", {31'd0, upg_done_o}, 32'd1);

        // Framing error in the middle of a data word.
        base = n_strb;
        pulse_start();
        send_bytes(s4, 5);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        chk("s4_err", {31'd0, err_o}, 32'd1);
        chk("s4_nstrb", n_strb - base, 0);
        chk("s4_done", {31'd0, upg_done_o}, 32'd0);
        pulse_start();
        chk("s4_err_clr", {31'd0, err_o}, 32'd0);

        // Bad header target (session already in HDR from the start above).
        base = n_strb;
        send_bytes(s5, 8);
        repeat (10) @(negedge clk);
        chk("s5_err", {31'd0, err_o}, 32'd1);
        chk("s5_nstrb", n_strb - base, 0);
        chk("s5_done", {31'd0, upg_done_o}, 32'd0);

        // Reset in the middle of a data word.
        pulse_start();
        send_bytes(s6, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_rst_err", {31'd0, err_o}, 32'd0);
        chk("s6_rst_dat", upg_dat_o, 32'd0);
        base = n_strb;
        pulse_start();
        send_bytes(s7, 7);
        repeat (10) @(negedge clk);
        chk("s6_nstrb", n_strb - base, 1);
        chk("s6_adr", {17'd0, log_adr[base]}, 32'h0000);
        chk("s6_dat", log_dat[base], 32'hDDCCBBAA);
        chk("s6_done", {31'd0, upg_done_o}, 32'd1);

        // Quarter-bit glitch and a stray start_pg during DATA.
        base = n_strb;
        pulse_start();
        send_bytes(s8, 3);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'hAA, 1'b1);
        pulse_start();
        send_bytes(s9, 3);
        repeat (10) @(negedge clk);
        chk("s7_nstrb", n_strb - base, 1);
        chk("s7_dat", log_dat[base], 32'hDDCCBBAA);
        chk("s7_done", {31'd0, upg_done_o}, 32'd1);
        chk("s7_err", {31'd0, err_o}, 32'd0);

        chk("wen_single_cycle", dbl_wen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_programmer.md
UART_PROGRAMMER -- requirements
Module: uart_programmer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clk cycles per UART bit (10 MHz uart_clk / 115200 baud).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start_pg, input, 1 bit: a one-cycle pulse that arms a new programming session.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous UART serial line, 8N1, idle high.
REQ-006 SHALL have port upg_wen_o, output, 1 bit: one-cycle memory write strobe.
REQ-007 SHALL have port upg_adr_o, output, 15 bits: word address; bit 14 selects the target (0 = instruction ROM, 1 = data RAM), bits 13:0 are the word index.
REQ-008 SHALL have port upg_dat_o, output, 32 bits: the assembled write word.
REQ-009 SHALL have port upg_done_o, output, 1 bit: session completed successfully (level).
REQ-010 SHALL have port err_o, output, 1 bit: sticky framing or header error flag.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-012 SHALL implement the receiver FSM RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE:
- RX_IDLE leaves on a synchronized falling edge.
- RX_START re-samples at CLKS_PER_BIT/2; if the line is high (glitch), it returns to RX_IDLE.
- RX_DATA samples 8 bits, LSB first, every CLKS_PER_BIT cycles.
- RX_STOP samples once, then returns to RX_IDLE.
REQ-013 SHALL raise an internal byte_valid pulse for exactly 1 cycle, in the cycle after the stop-bit sample, only when the stop bit is 1.
REQ-014 SHALL treat a 0 stop bit as a framing error: no byte_valid, err_o set to 1, session FSM forced to ERR.
REQ-015 SHALL implement the session FSM with states IDLE, HDR, DATA, DONE, ERR.
- Received bytes are ignored in IDLE, DONE and ERR.
REQ-016 SHALL honour start_pg only in IDLE, DONE or ERR: it enters HDR and clears upg_done_o, err_o, the byte counter and the word index.
- start_pg in HDR or DATA is ignored.
REQ-017 SHALL take the 3-byte header in HDR:
- Byte 0 is the target: 0x00 = ROM, 0x01 = RAM; any other value sets err_o and enters ERR.
- Bytes 1-2 are word count N, little-endian; bits 15:14 are ignored, so N ranges 0..16383.
REQ-018 SHALL handle N = 0 by going from HDR directly to DONE after byte 2, with no write.
REQ-019 SHALL assemble each data word from 4 bytes, little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-020 SHALL pulse upg_wen_o for exactly 1 cycle, in the cycle after the byte_valid of each word's 4th byte.
- In that cycle: upg_dat_o = the assembled word, upg_adr_o = {target, index}.
- The index starts at 0 and increments after each write.
REQ-021 SHALL hold upg_adr_o and upg_dat_o stable between strobes.
REQ-022 SHALL enter DONE after the Nth write strobe.
- upg_done_o rises in the cycle after that strobe and holds until rst or an accepted start_pg.
REQ-023 SHALL not let the word index wrap: at most N ≤ 16383 writes occur, so the index never exceeds 16382.
REQ-024 SHALL give a framing error during DATA priority: it abandons the session and leaves the partial word unwritten.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set:
- both FSMs to IDLE;
- synchronizer flops to 1;
- upg_wen_o = 0, upg_adr_o = 0, upg_dat_o = 0, upg_done_o = 0, err_o = 0;
- all counters to 0.
REQ-026 SHALL give rst priority over start_pg and rx activity.
- Reset mid-session discards everything received so far.
- After reset, a new start_pg is required before bytes are accepted.

Verification
REQ-027 SHALL have a bench that covers these directed scenarios (CLKS_PER_BIT = 87):
- start_pg; bytes 00 02 00 78 56 34 12 EF BE AD DE -> strobes at adr 0x0000 dat 0x12345678, then adr 0x0001 dat 0xDEADBEEF; upg_done_o = 1 after the second strobe.
- start_pg; header 01 01 00 + 11 22 33 44 -> one strobe, adr 0x4000, dat 0x44332211, done = 1.
- start_pg; header 00 00 00 -> no strobe, done = 1 one cycle after the last header byte.
- Byte with stop bit 0 during DATA -> err_o = 1, no further strobes, done stays 0; a new start_pg clears err_o.
- Header target 0x05 -> err_o = 1, state ERR, subsequent bytes ignored.
- rst asserted after 2 of 4 data bytes; then start_pg + 00 01 00 AA BB CC DD -> single strobe, adr 0, dat 0xDDCCBBAA.
- A 1/4-bit low glitch on rx in IDLE produces no byte; start_pg during DATA is ignored.
